// File: rtl/axilite_csr_write_resp.sv
// AXI-Lite B-channel stage: in-order response FIFO feeding bvalid/bresp, plus write statistics.
// Push is visible on bvalid the cycle after the sampling edge; full is a pure registered-occupancy decode.
module axilite_csr_write_resp #(
  parameter int         DEPTH       = 2,
  parameter int         COUNT_WIDTH = 16,
  parameter logic [1:0] RESP_OKAY   = 2'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               resp,
  input  logic                     resp_valid,
  output logic                     full,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [COUNT_WIDTH-1:0]   err_count,
  output logic [COUNT_WIDTH-1:0]   done_count,
  output logic                     overflow,
  input  logic                     clear_stats
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          push;
  logic          pop;
  logic          drop;
  logic          err_inc;

  assign full    = (occ == FULL_CNT);
  assign bvalid  = (occ != '0);
  assign bresp   = bvalid ? mem[rd_ptr] : 2'b00;
  assign count   = occ;

  // A push against a full FIFO is dropped even if a pop frees a slot this same edge.
  assign push    = resp_valid && !full;
  assign drop    = resp_valid && full;
  assign pop     = bvalid && bready;
  assign err_inc = push && (resp != RESP_OKAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 2'b00;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= resp;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        occ <= occ + (AW+1)'(1);
      end else if (pop && !push) begin
        occ <= occ - (AW+1)'(1);
      end
    end
  end

  // Clear beats a same-cycle increment on the counters, but a same-cycle drop keeps overflow set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      done_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (clear_stats) begin
        err_count <= '0;
      end else if (err_inc && (err_count != '1)) begin
        err_count <= err_count + COUNT_WIDTH'(1);
      end
      if (clear_stats) begin
        done_count <= '0;
      end else if (pop) begin
        done_count <= done_count + COUNT_WIDTH'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_stats) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axilite_csr_write_resp.sv
// Randomised plus directed bench for axilite_csr_write_resp against a queue-based reference model.
module tb_axilite_csr_write_resp;

  localparam int DEPTH = 2;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    resp = 2'd0;
  logic          resp_valid = 1'b0;
  logic          bready = 1'b0;
  logic          clear_stats = 1'b0;
  logic          full;
  logic [1:0]    bresp;
  logic          bvalid;
  logic [1:0]    count;
  logic [CW-1:0] err_count;
  logic [CW-1:0] done_count;
  logic          overflow;

  int n_vec  = 0;
  int n_fail = 0;

  axilite_csr_write_resp #(.DEPTH(DEPTH), .COUNT_WIDTH(CW), .RESP_OKAY(2'd0)) dut (
    .clk(clk), .rst_n(rst_n), .resp(resp), .resp_valid(resp_valid), .full(full),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .count(count),
    .err_count(err_count), .done_count(done_count), .overflow(overflow),
    .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending responses plus plain statistics.
  logic [1:0] mq[$];
  int         m_err  = 0;
  int         m_done = 0;
  bit         m_ovf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_err  = 0;
      m_done = 0;
      m_ovf  = 1'b0;
    end else begin
      bit was_full;
      bit do_pop;
      bit ovf_evt;
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() != 0) && bready;
      ovf_evt  = resp_valid && was_full;
      if (do_pop) begin
        void'(mq.pop_front());
        m_done = (m_done + 1) % (1 << CW);
      end
      if (resp_valid && !was_full) begin
        mq.push_back(resp);
        if (resp != 2'd0 && m_err < (1 << CW) - 1) m_err = m_err + 1;
      end
      if (clear_stats) begin
        m_err  = 0;
        m_done = 0;
        m_ovf  = ovf_evt;
      end else if (ovf_evt) begin
        m_ovf = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("bvalid", int'(bvalid), int'(sz != 0));
    chk("bresp", int'(bresp), (sz != 0) ? int'(mq[0]) : 0);
    chk("full", int'(full), int'(sz == DEPTH));
    chk("count", int'(count), sz);
    chk("err_count", int'(err_count), m_err);
    chk("done_count", int'(done_count), m_done);
    chk("overflow", int'(overflow), int'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] r, input bit rdy, input bit clr);
    resp_valid  = v;
    resp        = r;
    bready      = rdy;
    clear_stats = clr;
    tick();
  endtask

  initial begin
    // Pushes during reset must be ignored.
    resp_valid = 1'b1;
    resp       = 2'd2;
    repeat (3) tick();
    resp_valid = 1'b0;
    rst_n      = 1'b1;
    tick();
    chk("rst_bvalid", int'(bvalid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_stats", int'(err_count) + int'(done_count) + int'(overflow), 0);

    // Single OKAY with bready high: visible after edge 1, handshake at edge 2.
    drive(1, 2'd0, 1, 0);
    chk("single_bvalid", int'(bvalid), 1);
    chk("single_bresp", int'(bresp), 0);
    drive(0, 2'd0, 1, 0);
    chk("single_done_bvalid", int'(bvalid), 0);
    chk("single_done_count", int'(done_count), 1);
    chk("single_err_count", int'(err_count), 0);

    // Backpressure and overflow.
    drive(0, 2'd0, 0, 1);
    drive(1, 2'd2, 0, 0);
    drive(1, 2'd0, 0, 0);
    chk("bp_full", int'(full), 1);
    chk("bp_count", int'(count), 2);
    chk("bp_bresp", int'(bresp), 2);
    drive(1, 2'd1, 0, 0);
    chk("bp_overflow", int'(overflow), 1);
    chk("bp_count_hold", int'(count), 2);
    chk("bp_bresp_hold", int'(bresp), 2);
    drive(0, 2'd0, 1, 0);
    chk("drain_bresp1", int'(bresp), 0);
    drive(0, 2'd0, 1, 0);
    chk("drain_empty", int'(bvalid), 0);
    chk("drain_done", int'(done_count), 2);
    chk("drain_err", int'(err_count), 1);

    // Concurrent push and pop at count 1, across several pointer wraps.
    drive(1, 2'd2, 0, 0);
    drive(1, 2'd0, 1, 0);
    chk("conc_count", int'(count), 1);
    chk("conc_bresp", int'(bresp), 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 2'(i), 1, 0);
      chk("conc_wrap_bresp", int'(bresp), i % 4);
    end
    drive(0, 2'd0, 1, 0);

    // Saturation and clear.
    drive(0, 2'd0, 1, 1);
    for (int i = 0; i < 17; i++) drive(1, 2'd2, 1, 0);
    chk("sat_err", int'(err_count), 15);
    drive(1, 2'd2, 1, 1);
    chk("clr_vs_inc", int'(err_count), 0);
    drive(0, 2'd0, 1, 0);
    drive(1, 2'd3, 0, 0);
    drive(1, 2'd1, 0, 0);
    drive(1, 2'd2, 0, 1);
    chk("clr_vs_ovf", int'(overflow), 1);

    // Asynchronous reset between edges with a full FIFO.
    resp_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bvalid", int'(bvalid), 0);
    chk("arst_full", int'(full), 0);
    chk("arst_count", int'(count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1, 2'd3, 0, 0);
    chk("post_rst_bvalid", int'(bvalid), 1);
    chk("post_rst_bresp", int'(bresp), 3);
    drive(0, 2'd0, 1, 0);

    // Random traffic; compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 3)) rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end

    drive(0, 2'd0, 1, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/axilite_csr_write_resp.md
# axilite_csr_write_resp

AXI-Lite write-response (B channel) stage for the CSR slave. It consumes the per-beat `resp`/`resp_valid` result from the write-data stage and queues it in a small in-order FIFO. It presents each entry on `bvalid`/`bresp` until the master accepts it. It also drives `full` back to the write-data stage for flow control and keeps write statistics (error count, completion count, sticky overflow).

## Interface

Parameters:
- `DEPTH`, 2: response FIFO entries; power of two, ≥2.
- `COUNT_WIDTH`, 16: width of the statistics counters.
- `RESP_OKAY`, 0: response encoding treated as success; every other code counts as an error.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `resp`  in  2  write result from the write-data stage.
- `resp_valid`  in  1  one-cycle push strobe for `resp`.
- `full`  out  1  FIFO holds `DEPTH` entries; the write-data stage must not complete a beat while this is high.
- `bresp`  out  2  AXI BRESP; head entry of the FIFO.
- `bvalid`  out  1  AXI BVALID.
- `bready`  in  1  AXI BREADY.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `err_count`  out  COUNT_WIDTH  accepted non-OKAY responses; saturating.
- `done_count`  out  COUNT_WIDTH  completed B handshakes; wrapping.
- `overflow`  out  1  sticky flag: a `resp_valid` arrived while `full`.
- `clear_stats`  in  1  synchronous clear of `err_count`, `done_count` and `overflow`.

## Operation

- **Storage:** circular buffer of `DEPTH` × 2-bit entries, with write pointer, read pointer and occupancy counter.
- **Push:** when `resp_valid` is high and `count < DEPTH` at the edge, `resp` is written at the write pointer, and the write pointer and `count` advance.
- **Dropped push:** `resp_valid` with `count == DEPTH` is dropped, even if a pop occurs in the same cycle. The FIFO is unchanged and `overflow` is set.
- **Pop:** when `bvalid` and `bready` are both high at the edge, the read pointer advances and `count` decrements.
- **Simultaneous push and pop** (count between 1 and DEPTH−1): `count` is unchanged, both pointers advance, and order is preserved.
- **Pointer wrap:** pointers wrap modulo `DEPTH`.
- **Output encoding:**
  - `bvalid = (count != 0)`.
  - `bresp` = entry at the read pointer, driven as 0 when the FIFO is empty.
  - `full = (count == DEPTH)`.
- **AXI rule:** once `bvalid` is high, `bvalid` and `bresp` hold stable until the handshake, regardless of pushes.
- **No bypass:** an empty FIFO never forwards `resp` combinationally to `bresp`.
- **`err_count`:** +1 on every accepted push with `resp != RESP_OKAY`; saturates at all-ones. Dropped pushes are not counted.
- **`done_count`:** +1 on every B handshake; wraps to 0.
- **`clear_stats`:**
  - Counters: clear wins over a same-cycle increment; result is 0.
  - `overflow`: a same-cycle set wins over the clear, so the event is not lost.
  - FIFO contents are unaffected.
- **Reset:**
  - Asynchronous assertion empties the FIFO, zeroes pointers and all counters, and clears `overflow`.
  - Pending responses are discarded; `bvalid` falls immediately, without waiting for an edge.
  - Deassertion is taken synchronously at the next edge.

## Timing

- **Reset values:** `bvalid`=0, `bresp`=0, `full`=0, `count`=0, `err_count`=0, `done_count`=0, `overflow`=0.
- **Latency:** `resp_valid` sampled at edge N → `bvalid`=1 and `bresp` valid after edge N. With `bready` high, the handshake occurs at edge N+1.
- **Throughput:** one push and one pop per cycle. The write-data stage issues at most one `resp_valid` every two cycles, so a 2-entry FIFO never overflows when `full` is honoured.
- **Output timing:** `full`, `count` and the statistics outputs are registered-state decodes, valid in the cycle after the causing edge. `full` has no combinational path from `bready`.
- **Input timing:** `bready` may change in any cycle. `bready` high while `bvalid` is low has no effect.

## Test plan

- **Reset:** hold `rst_n` low mid-simulation → all outputs 0; pushes while in reset are ignored.
- **Single OKAY, `bready`=1:** `resp`=0 pulse at edge 1 → after edge 1 `bvalid`=1, `bresp`=0. Handshake at edge 2 → `bvalid`=0, `done_count`=1, `err_count`=0.
- **Backpressure and overflow, `bready`=0, DEPTH=2:**
  - Push SLVERR(2), then OKAY(0) → `full`=1, `count`=2, `bresp`=2 held stable.
  - Third push → dropped, `overflow`=1, `count`=2.
  - Raise `bready` → `bresp` sequence 2 then 0, final `done_count`=2, `err_count`=1.
- **Concurrent push and pop at `count`=1**, queue holding [2], push 0 → after the edge `count`=1, `bresp`=0. Repeat across pointer wrap; order preserved.
- **Saturation and clear, COUNT_WIDTH=4:**
  - 17 accepted SLVERR pushes → `err_count`=15.
  - `clear_stats` in the same cycle as a SLVERR push → `err_count`=0.
  - `clear_stats` in the same cycle as an overflow push → `overflow`=1.
- **Reset mid-operation:** with `count`=2, drop `rst_n` between edges → `bvalid`=0, `full`=0 immediately. After release, a new push is delivered normally.
